// File: rtl/ball_bbox_tracker.sv
// ball_bbox_tracker: per-colour bounding box and pixel count over one frame.
// Pixels arrive one per in_valid cycle from the colour classifier. Classes
// 1..5 each keep a bounding box and a saturating pixel count. On an accepted
// eof pixel the five accumulators are copied into shadow registers (when the
// emitter is idle) and then streamed as five records, class 1 first.
// Accumulation of the next frame proceeds while the records drain.
//
// Result handshake: a record transfers on a rising edge where
// res_valid && res_ready. Once res_valid rises it stays high, and every
// res_* output holds stable, until that transfer. res_valid never depends
// combinationally on res_ready.
module ball_bbox_tracker #(
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int XW         = 11,
  parameter int YW         = 10,
  parameter int CW         = 16,
  parameter int MIN_PIXELS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [2:0]    in_class,
  input  logic          in_sof,
  input  logic          in_eol,
  input  logic          in_eof,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [2:0]    res_class,
  output logic          res_found,
  output logic [XW-1:0] res_xmin,
  output logic [XW-1:0] res_xmax,
  output logic [YW-1:0] res_ymin,
  output logic [YW-1:0] res_ymax,
  output logic [CW-1:0] res_count,
  output logic          overrun
);

  localparam int            NC      = 5;
  localparam logic [XW-1:0] X_LAST  = XW'(IMAGE_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMAGE_H - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

  // The state value is the class currently being presented (0 = idle).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EMIT1 = 3'd1;
  localparam logic [2:0] ST_EMIT5 = 3'd5;

  logic [2:0]             state_q, state_d;
  logic                   synced_q, synced_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   overrun_q, overrun_d;

  logic [NC-1:0][XW-1:0]  acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [NC-1:0][YW-1:0]  acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic [NC-1:0][CW-1:0]  acc_cnt_q, acc_cnt_d;

  logic [NC-1:0][XW-1:0]  sh_xmin_q, sh_xmin_d, sh_xmax_q, sh_xmax_d;
  logic [NC-1:0][YW-1:0]  sh_ymin_q, sh_ymin_d, sh_ymax_q, sh_ymax_d;
  logic [NC-1:0][CW-1:0]  sh_cnt_q, sh_cnt_d;

  logic                   take;
  logic                   latch;
  logic [XW-1:0]          cur_x;
  logic [YW-1:0]          cur_y;

  // Pixel acceptance, coordinates, accumulation and end-of-frame latch.
  always_comb begin
    synced_d   = synced_q;
    x_d        = x_q;
    y_d        = y_q;
    overrun_d  = 1'b0;
    latch      = 1'b0;
    acc_xmin_d = acc_xmin_q;
    acc_xmax_d = acc_xmax_q;
    acc_ymin_d = acc_ymin_q;
    acc_ymax_d = acc_ymax_q;
    acc_cnt_d  = acc_cnt_q;
    sh_xmin_d  = sh_xmin_q;
    sh_xmax_d  = sh_xmax_q;
    sh_ymin_d  = sh_ymin_q;
    sh_ymax_d  = sh_ymax_q;
    sh_cnt_d   = sh_cnt_q;

    // Before the first sof nothing is known about position, so pixels are dropped.
    take  = in_valid && (synced_q || in_sof);
    cur_x = in_sof ? '0 : x_q;
    cur_y = in_sof ? '0 : y_q;

    if (take) begin
      synced_d = 1'b1;
      // A sof pixel starts fresh; any partial frame is thrown away.
      if (in_sof) begin
        acc_xmin_d = '0;
        acc_xmax_d = '0;
        acc_ymin_d = '0;
        acc_ymax_d = '0;
        acc_cnt_d  = '0;
      end
      for (int c = 0; c < NC; c++) begin
        if (in_class == 3'(c + 1)) begin
          if (acc_cnt_d[c] == '0) begin
            acc_xmin_d[c] = cur_x;
            acc_xmax_d[c] = cur_x;
            acc_ymin_d[c] = cur_y;
            acc_ymax_d[c] = cur_y;
          end else begin
            if (cur_x < acc_xmin_d[c]) acc_xmin_d[c] = cur_x;
            if (cur_x > acc_xmax_d[c]) acc_xmax_d[c] = cur_x;
            if (cur_y < acc_ymin_d[c]) acc_ymin_d[c] = cur_y;
            if (cur_y > acc_ymax_d[c]) acc_ymax_d[c] = cur_y;
          end
          if (acc_cnt_d[c] != CNT_MAX) acc_cnt_d[c] = acc_cnt_d[c] + CW'(1);
        end
      end
      if (in_eol) begin
        x_d = '0;
        y_d = (cur_y != Y_LAST) ? cur_y + YW'(1) : cur_y;
      end else begin
        x_d = (cur_x != X_LAST) ? cur_x + XW'(1) : cur_x;
        y_d = cur_y;
      end
      // The eof pixel's own contribution is already folded into acc_*_d.
      if (in_eof) begin
        if (state_q == ST_IDLE) begin
          latch     = 1'b1;
          sh_xmin_d = acc_xmin_d;
          sh_xmax_d = acc_xmax_d;
          sh_ymin_d = acc_ymin_d;
          sh_ymax_d = acc_ymax_d;
          sh_cnt_d  = acc_cnt_d;
        end else begin
          overrun_d = 1'b1;
        end
        acc_xmin_d = '0;
        acc_xmax_d = '0;
        acc_ymin_d = '0;
        acc_ymax_d = '0;
        acc_cnt_d  = '0;
      end
    end
  end

  // Emit sequencer: idle, then one state per class, advancing on each transfer.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (latch) state_d = ST_EMIT1;
    end else if (state_q > ST_EMIT5) begin
      state_d = ST_IDLE;
    end else if (res_ready) begin
      state_d = (state_q == ST_EMIT5) ? ST_IDLE : state_q + 3'd1;
    end
  end

  // Record presentation from the shadow selected by the current state.
  always_comb begin
    logic [2:0] sel;
    sel       = state_q - 3'd1;
    res_valid = 1'b0;
    res_class = '0;
    res_found = 1'b0;
    res_xmin  = '0;
    res_xmax  = '0;
    res_ymin  = '0;
    res_ymax  = '0;
    res_count = '0;
    if (state_q >= ST_EMIT1 && state_q <= ST_EMIT5) begin
      res_valid = 1'b1;
      res_class = state_q;
      res_count = sh_cnt_q[sel];
      res_found = (sh_cnt_q[sel] >= MIN_CNT);
      // An unfound class reports an empty box but still the true count.
      if (res_found) begin
        res_xmin = sh_xmin_q[sel];
        res_xmax = sh_xmax_q[sel];
        res_ymin = sh_ymin_q[sel];
        res_ymax = sh_ymax_q[sel];
      end
    end
  end

  assign overrun = overrun_q;

  // State registers; reset returns everything to idle and drops pending records.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      synced_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      overrun_q  <= 1'b0;
      acc_xmin_q <= '0;
      acc_xmax_q <= '0;
      acc_ymin_q <= '0;
      acc_ymax_q <= '0;
      acc_cnt_q  <= '0;
      sh_xmin_q  <= '0;
      sh_xmax_q  <= '0;
      sh_ymin_q  <= '0;
      sh_ymax_q  <= '0;
      sh_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      synced_q   <= synced_d;
      x_q        <= x_d;
      y_q        <= y_d;
      overrun_q  <= overrun_d;
      acc_xmin_q <= acc_xmin_d;
      acc_xmax_q <= acc_xmax_d;
      acc_ymin_q <= acc_ymin_d;
      acc_ymax_q <= acc_ymax_d;
      acc_cnt_q  <= acc_cnt_d;
      sh_xmin_q  <= sh_xmin_d;
      sh_xmax_q  <= sh_xmax_d;
      sh_ymin_q  <= sh_ymin_d;
      sh_ymax_q  <= sh_ymax_d;
      sh_cnt_q   <= sh_cnt_d;
    end
  end

endmodule

// File: doc/ball_bbox_tracker.md
Name: ball_bbox_tracker

Overview:
- Downstream of the per-pixel colour classifier. Consumes one 3-bit classification per pixel, together with raster framing flags.
- Accumulates, per ball colour (classes 1..5), the bounding box and pixel count over one frame.
- At end of frame, snapshots the results and streams five result records over a valid/ready interface to the rover's navigation/SoC readout.
- Accumulation of the next frame proceeds while the records drain.

Parameters:
- IMAGE_W, 640, pixels per line; x saturates at IMAGE_W-1.
- IMAGE_H, 480, lines per frame; y saturates at IMAGE_H-1.
- XW, 11, x coordinate width.
- YW, 10, y coordinate width.
- CW, 16, per-class pixel counter width.
- MIN_PIXELS, 16, minimum count for a class to be reported as found.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  pixel qualifier; one pixel is consumed per cycle with in_valid=1.
- in_class  in  3  classification (0 = none, 1 red, 2 yellow, 3 green, 4 blue, 5 pink, 6/7 = invalid).
- in_sof  in  1  first pixel of frame; meaningful only with in_valid.
- in_eol  in  1  last pixel of line; meaningful only with in_valid.
- in_eof  in  1  last pixel of frame; meaningful only with in_valid.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- res_class  out  3  class of the record, 1..5.
- res_found  out  1  count >= MIN_PIXELS.
- res_xmin  out  XW  bounding box left edge.
- res_xmax  out  XW  bounding box right edge.
- res_ymin  out  YW  bounding box top edge.
- res_ymax  out  YW  bounding box bottom edge.
- res_count  out  CW  classified pixel count, saturating.
- overrun  out  1  one-cycle pulse: frame result dropped.

Behaviour:
- Reset (async, rst=1): all outputs 0; accumulators cleared; x=y=0; synced flag=0; emit FSM in IDLE.

Synchronisation:
- Pixels are ignored until the first in_valid&in_sof; that pixel sets synced=1.
- synced never clears except on rst.

Coordinates:
- An in_sof pixel has x=0, y=0.
- After each accepted pixel, x increments (saturating at IMAGE_W-1).
- After an in_eol pixel, x goes to 0 and y increments (saturating at IMAGE_H-1).

Accumulation:
- An in_sof pixel first clears all five accumulators, then applies its own contribution in the same cycle.
- For each class c in 1..5 on an accepted pixel with in_class=c:
  - count++ (saturating at 2^CW-1).
  - On the first hit of the frame (count was 0), xmin=xmax=x and ymin=ymax=y.
  - Otherwise xmin=min, xmax=max, ymin=min, ymax=max.
- Classes 0, 6 and 7 change nothing.

Frame end:
- An accepted in_eof pixel (its own contribution included) latches all five accumulators into shadow registers on that clock edge, provided the FSM is IDLE.
- After latching, the accumulators clear.
- A pixel with in_sof and in_eof both set forms a 1-pixel frame; both rules apply.

Emit FSM:
- States: IDLE, EMIT(k), k = 1..5.
- IDLE -> EMIT(1) on the shadow latch. res_valid=1 on the cycle after the in_eof pixel edge (1-cycle latency).
- In EMIT(k), the outputs present shadow[k] with res_class=k and res_found=(count>=MIN_PIXELS).
- When res_found=0, the xmin/xmax/ymin/ymax outputs are 0 and res_count still shows the true count.
- A transfer occurs when res_valid&res_ready.
- On a transfer: EMIT(k) -> EMIT(k+1); EMIT(5) -> IDLE and res_valid=0.
- While res_valid=1 and res_ready=0, all res_* outputs hold stable.
- Back-to-back frames with res_ready tied high yield 5 consecutive valid cycles.

Overrun:
- An in_eof pixel arriving while the FSM is not IDLE does not latch the shadows; the new frame's results are discarded.
- In that case overrun=1 for exactly one cycle, the accumulators still clear, and the current emission continues unaffected.
- An eof on the same edge as the final EMIT(5) transfer counts as not-IDLE, so the frame is dropped.

Other boundary conditions:
- in_sof mid-frame: the partial frame is discarded without output.
- Missing in_eol: x saturates.
- rst asserted mid-emission: FSM returns to IDLE immediately, and pending records are lost.

Test Plan:
- 4x3 frame (IMAGE_W=4, IMAGE_H=3, MIN_PIXELS=2); class 1 at (1,0),(2,1); class 3 at (3,2) only; res_ready=1 → records k=1: found=1, x 1..2, y 0..1, count=2; k=3: found=0, coords 0, count=1; k=2,4,5: count=0. First res_valid comes on the cycle after the eof pixel.
- Same frame with res_ready held 0 for 10 cycles after res_valid rises → record k=1 held stable for all 10 cycles; 5 records are delivered once ready rises.
- Second eof arrives while record 2 is pending → overrun pulses for 1 cycle; the remaining records 2..5 still come from frame 1; no sixth record appears.
- Pixels with class 5 sent before any in_sof, then a normal frame containing no class 5 → record 5 count=0.
- Mid-frame in_sof after 20 pixels of class 4, then a frame with class 4 only at (0,0) → record 4 x 0..0, y 0..0, count=1.
- Assert rst during EMIT(3) → res_valid=0 asynchronously; the next frame's eof produces records starting at class 1.
